// File: rtl/oam_dma.sv
// Sprite DMA engine sitting between the CPU core and the system bus.
// When idle it passes CPU bus traffic straight through. A CPU write to
// DMA_REG_ADDR starts a 256-byte copy from page XX00-XXFF to the OAM data
// port, stalling the CPU through cpu_rdy until the copy completes.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_d_in,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_we,
  input  logic [7:0]  bus_d_in,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  latch;
  logic        parity;
  logic        trigger;

  // Read data always comes straight from the bus, DMA or not.
  assign cpu_d_in = bus_d_in;

  // Free-running get/put parity: reads must land on parity-0 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
    end
  end

  // State register plus page/index/data registers of the copy loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      latch <= 8'h00;
    end else begin
      state <= state_nxt;
      if (trigger) begin
        page <= cpu_d_out;
        idx  <= 8'h00;
      end
      if (state == READ) begin
        latch <= bus_d_in;
      end
      if (state == WRITE) begin
        // 8-bit wrap: the source address never carries into the page.
        idx <= idx + 8'd1;
      end
    end
  end

  // Next-state and bus steering; non-idle states default to a stalled CPU.
  always_comb begin
    state_nxt  = state;
    trigger    = 1'b0;
    cpu_rdy    = 1'b0;
    dma_active = 1'b1;
    bus_addr   = cpu_addr;
    bus_d_out  = cpu_d_out;
    bus_we     = 1'b0;
    case (state)
      IDLE: begin
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        // Trigger write itself still reaches the bus; nothing is written in reset.
        bus_we     = cpu_we & ~rst;
        trigger    = cpu_we && (cpu_addr == DMA_REG_ADDR);
        if (trigger) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        // Current parity 1 means the following cycle is a read slot.
        state_nxt = parity ? READ : ALIGN;
      end
      ALIGN: begin
        state_nxt = READ;
      end
      READ: begin
        bus_addr  = {page, idx};
        state_nxt = WRITE;
      end
      WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_d_out = latch;
        bus_we    = 1'b1;
        state_nxt = (idx == 8'hFF) ? IDLE : READ;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected bus reads/writes,
// an independent monitor pops and compares whatever the DUT puts on the bus.
module tb_oam_dma;

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic [7:0]  cpu_d_in;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic [7:0]  bus_d_in;
  logic        dma_active;

  logic [7:0]  mem [65536];
  logic [23:0] wq [$];
  logic [15:0] rq [$];
  logic [31:0] cyc;
  int          tests;
  int          fails;
  int          wr_seen;

  oam_dma #(.DMA_REG_ADDR(DMA_REG), .OAM_DATA_ADDR(OAM_DATA)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
    .cpu_we(cpu_we), .cpu_d_in(cpu_d_in), .cpu_rdy(cpu_rdy),
    .bus_addr(bus_addr), .bus_d_out(bus_d_out), .bus_we(bus_we),
    .bus_d_in(bus_d_in), .dma_active(dma_active)
  );

  // Memory model answers in the same cycle the address is presented.
  assign bus_d_in = mem[bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock count since reset; its LSB is the parity of the current cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rand_page();
    logic [7:0] p;
    do p = 8'($urandom_range(0, 255)); while (p == 8'h40);
    return p;
  endfunction

  // Reference model of one DMA: 256 reads in ascending order, each followed
  // by an OAM write of the byte just read, all inside the source page.
  task automatic push_dma(input logic [7:0] pg);
    for (int i = 0; i < 256; i++) begin
      rq.push_back({pg, 8'(i)});
      wq.push_back({OAM_DATA, mem[{pg, 8'(i)}]});
    end
  endtask

  // Issue a trigger at the current negedge and wait for the stall to end.
  task automatic run_dma(input logic [7:0] pg, input bit ignore);
    int exp_stall;
    int n;
    exp_stall = (cyc[0] == 1'b0) ? 513 : 514;
    wq.push_back({DMA_REG, pg});
    push_dma(pg);
    cpu_addr  = DMA_REG;
    cpu_d_out = pg;
    cpu_we    = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cpu_rdy && n < 600) begin
      n++;
      if (ignore) begin
        cpu_addr  = DMA_REG;
        cpu_d_out = 8'($urandom);
        cpu_we    = 1'b1;
      end else begin
        cpu_addr  = 16'h4015;
        cpu_we    = 1'b0;
      end
      @(negedge clk);
    end
    cpu_we   = 1'b0;
    cpu_addr = 16'h4015;
    chk("stall_len", n, exp_stall);
    chk("queues_drained", wq.size() + rq.size(), 0);
  endtask

  task automatic align_to(input bit p);
    if (cyc[0] != p) @(negedge clk);
  endtask

  // Monitor: every bus write and every DMA source read is matched in order.
  initial begin
    logic [23:0] ew;
    logic [15:0] er;
    forever begin
      @(negedge clk);
      #3;
      if (bus_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", bus_addr, 16'hxxxx);
        end else begin
          ew = wq.pop_front();
          chk("write_addr", bus_addr, ew[23:8]);
          chk("write_data", bus_d_out, ew[7:0]);
          if (bus_addr == OAM_DATA) wr_seen++;
        end
      end else if (!cpu_rdy && bus_addr != cpu_addr) begin
        if (rq.size() == 0) begin
          chk("unexpected_read_addr", bus_addr, 16'hxxxx);
        end else begin
          er = rq.pop_front();
          chk("read_addr", bus_addr, er);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, limit 500000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    int w0;
    logic [15:0] a;
    logic [7:0]  d;
    tests = 0;
    fails = 0;
    wr_seen = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    // Reset with a CPU write pending: nothing may reach the bus.
    rst = 1'b1; cpu_addr = 16'h0300; cpu_d_out = 8'h11; cpu_we = 1'b1;
    @(negedge clk); @(negedge clk);
    #2;
    chk("rst_cpu_rdy", cpu_rdy, 1'b1);
    chk("rst_dma_active", dma_active, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    @(negedge clk);
    rst = 1'b0; cpu_we = 1'b0;
    @(negedge clk);

    // Idle pass-through.
    wq.push_back({16'h0300, 8'h5A});
    cpu_addr = 16'h0300; cpu_d_out = 8'h5A; cpu_we = 1'b1;
    #2;
    chk("pt_bus_addr", bus_addr, 16'h0300);
    chk("pt_bus_d_out", bus_d_out, 8'h5A);
    chk("pt_bus_we", bus_we, 1'b1);
    chk("pt_cpu_rdy", cpu_rdy, 1'b1);
    chk("pt_cpu_d_in", cpu_d_in, mem[16'h0300]);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      do a = 16'($urandom); while (a == DMA_REG);
      d = 8'($urandom);
      cpu_addr = a; cpu_d_out = d; cpu_we = 1'($urandom);
      if (cpu_we) wq.push_back({a, d});
      #2;
      chk("pt_rand_addr", bus_addr, a);
      chk("pt_rand_d_in", cpu_d_in, mem[a]);
      chk("pt_rand_active", dma_active, 1'b0);
    end
    @(negedge clk);
    cpu_we = 1'b0;
    @(negedge clk);

    // Full copy from page 02 triggered on a parity-0 cycle.
    align_to(1'b0);
    run_dma(8'h02, 1'b0);
    // Random page triggered on a parity-1 cycle (needs the extra align cycle).
    repeat (3) @(negedge clk);
    align_to(1'b1);
    run_dma(rand_page(), 1'b0);
    // Page FF with DMA-register writes hammered during the copy.
    repeat (2) @(negedge clk);
    run_dma(8'hFF, 1'b1);
    // Back-to-back: second trigger in the first idle cycle.
    @(negedge clk);
    run_dma(rand_page(), 1'b0);
    run_dma(rand_page(), 1'b0);

    // Reset in the middle of a transfer.
    @(negedge clk);
    base = wr_seen;
    d = rand_page();
    wq.push_back({DMA_REG, d});
    push_dma(d);
    cpu_addr = DMA_REG; cpu_d_out = d; cpu_we = 1'b1;
    @(negedge clk);
    cpu_addr = 16'h4015; cpu_we = 1'b0;
    n = 0;
    while (wr_seen < base + 100 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("mid_wait_100_writes", wr_seen - base, 100);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cpu_rdy", cpu_rdy, 1'b1);
    chk("mid_rst_dma_active", dma_active, 1'b0);
    chk("mid_rst_bus_we", bus_we, 1'b0);
    wq.delete();
    rq.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    w0 = wr_seen;
    repeat (40) @(negedge clk);
    chk("post_rst_no_writes", wr_seen - w0, 0);
    chk("post_rst_cpu_rdy", cpu_rdy, 1'b1);

    // Engine still works after the abort.
    run_dma(rand_page(), 1'b0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine between the `cpu` core's bus outputs (`addr`, `d_out`, write strobe) and the system bus/memory map.
- A CPU write to the DMA register starts a 256-byte copy from CPU page XX00–XXFF to the PPU OAM data port.
- While the copy runs, the CPU is stalled via `cpu_rdy`.
- When idle, the block is a transparent pass-through of CPU bus traffic.

Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU write address that triggers DMA; the written byte is the source page.
- `OAM_DATA_ADDR`, 16'h2004, bus address every DMA write targets.

Ports:
- `clk`  in  1  system clock; one CPU cycle per rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  16  address from cpu core.
- `cpu_d_out`  in  8  write data from cpu core.
- `cpu_we`  in  1  cpu write strobe (1 = write cycle).
- `cpu_d_in`  out  8  read data to cpu core.
- `cpu_rdy`  out  1  0 = cpu must hold all state this cycle.
- `bus_addr`  out  16  address to system bus.
- `bus_d_out`  out  8  write data to system bus.
- `bus_we`  out  1  bus write strobe.
- `bus_d_in`  in  8  bus read data, valid in the same cycle `bus_addr` is presented.
- `dma_active`  out  1  1 while the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous and active-high (`rst`).
- Reset values:
  - state=IDLE, page=0, idx=0, latch=0, parity=0.
  - `cpu_rdy`=1, `dma_active`=0.
  - `bus_we` is forced 0 while `rst`=1.
- `parity` flop toggles every clock; used for get/put alignment.
- `cpu_d_in` = `bus_d_in` combinationally, at all times.
- IDLE:
  - `bus_addr`/`bus_d_out`/`bus_we` = `cpu_addr`/`cpu_d_out`/`cpu_we`.
  - The trigger write itself passes through to the bus.
  - Trigger condition: `cpu_we` && `cpu_addr`==`DMA_REG_ADDR`.
  - On trigger, capture page<=`cpu_d_out`, idx<=0, next state HALT.
- HALT (1 cycle):
  - `cpu_rdy`=0, `bus_we`=0, `bus_addr`=`cpu_addr` (dummy).
  - Next state READ if the next cycle has parity 0 (current parity==1), else ALIGN.
- ALIGN (1 cycle): `cpu_rdy`=0, `bus_we`=0; next state READ.
- READ:
  - `bus_addr`={page, idx}, `bus_we`=0.
  - latch<=`bus_d_in` at the closing edge; next state WRITE.
- WRITE:
  - `bus_addr`=`OAM_DATA_ADDR`, `bus_d_out`=latch, `bus_we`=1; idx<=idx+1 (8-bit).
  - If idx==255, next state IDLE; else READ.
- `cpu_rdy`=0 and `dma_active`=1 in HALT, ALIGN, READ and WRITE; `cpu_rdy` returns to 1 the cycle after the last WRITE.
- Total stall, counted from the cycle after the trigger:
  - 513 cycles if no ALIGN.
  - 514 cycles if ALIGN.
- Source address never carries into the page: page FF reads FF00–FFFF only.
- While not IDLE, `cpu_we`/`cpu_addr`/`cpu_d_out` are ignored and no re-trigger is possible.
- A trigger in the first IDLE cycle after completion is accepted normally.
- Reset mid-transfer: immediate return to IDLE with reset values. Partial OAM writes already issued stand; no further bus writes are issued.
- Bus timing: READ and WRITE strictly alternate. Exactly 256 READs and 256 WRITEs per DMA, in ascending idx order.

Test Plan:
- Idle pass-through: `cpu_addr`=16'h0300, `cpu_we`=1, `cpu_d_out`=8'h5A with no trigger -> `bus_addr`=16'h0300, `bus_we`=1, `bus_d_out`=8'h5A; `cpu_rdy`=1; `cpu_d_in` tracks `bus_d_in`.
- Full copy: memory model holds 16'h0200+i = i^8'hA5. Write 8'h02 to 16'h4014 -> 256 writes to 16'h2004 carrying 8'hA5, 8'hA4, … 8'h5A in order; reads go to 16'h0200..16'h02FF.
- Alignment: trigger in a cycle with parity 0 -> `cpu_rdy` low for exactly 513 cycles. Trigger with parity 1 -> 514 cycles, with the first READ on a parity-0 cycle.
- Page FF: trigger with 8'hFF -> last read is at 16'hFFFF; no access to 16'h0000; FSM returns to IDLE.
- Reset mid-transfer: assert `rst` asynchronously after the 100th OAM write -> same cycle `cpu_rdy`=1, `dma_active`=0, `bus_we`=0. After release, no further writes to 16'h2004 occur without a new trigger.
- Back-to-back and ignored writes:
  - CPU drives 16'h4014 writes during an active DMA -> ignored; 256 writes total.
  - A trigger in the first IDLE cycle after completion -> a second DMA of 256 writes starts.
